// File: rtl/or_accum_pkg.sv
// Shared types and helpers for the windowed OR accumulator.
//   or_accum_state_t : FSM encoding (IDLE / ACCUM / HOLD)
//   cnt_w(window)    : width needed to hold a sample count of 0..window
package or_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } or_accum_state_t;

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/or_window_accum_if.sv
// Handshake bundle for or_window_accum.
//   master : upstream/downstream driver side (drives samples, flush, out_ready)
//   slave  : the accumulator itself
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; valid never depends on ready on the same
// side, and a producer holds its payload stable while valid is 1 and ready 0.
interface or_window_accum_if
  import or_accum_pkg::*;
#(
  parameter int W      = 8,
  parameter int WINDOW = 4
) ();

  localparam int CNT_W = cnt_w(WINDOW);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/or_window_accum_my_or.sv
// my_or: single-bit OR cell used as the per-bit front end of the accumulator.
//   a_i, b_i : operand bits
//   y_o      : a_i | b_i
module my_or (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i | b_i;

endmodule

// File: rtl/or_window_accum.sv
// or_window_accum: ORs each accepted (a,b) pair bitwise, accumulates the
// results across up to WINDOW samples and presents the word plus the sample
// count on a valid/ready output. A flush pulse closes a non-empty window early.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : or_window_accum_if slave (input samples, flush, result)
//   state_o    : current FSM state, for observation
module or_window_accum
  import or_accum_pkg::*;
#(
  parameter int W      = 8,
  parameter int WINDOW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  or_window_accum_if.slave    bus,
  output or_accum_state_t     state_o
);

  localparam int               CNT_W = cnt_w(WINDOW);
  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  or_accum_state_t  state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [W-1:0]     or_ab;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             emit_hs;
  logic [W-1:0]     acc_nx;
  logic [CNT_W-1:0] cnt_nx;

  for (genvar i = 0; i < W; i++) begin : g_or
    my_or u_or (
      .a_i (bus.in_a[i]),
      .b_i (bus.in_b[i]),
      .y_o (or_ab[i])
    );
  end

  // Upstream is stalled only while a finished window waits to be taken.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = bus.in_valid & in_ready;
  assign emit_hs   = out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    // Window contents including this cycle's sample, if any.
    acc_nx      = accept ? (acc_q | or_ab) : acc_q;
    cnt_nx      = accept ? (cnt_q + ONE_C) : cnt_q;

    unique case (state_q)
      IDLE: begin
        // flush is meaningless with an empty window, so it is not looked at.
        if (accept) begin
          acc_d = or_ab;
          cnt_d = ONE_C;
          if (WIN_C == ONE_C) begin
            state_d     = HOLD;
            out_data_d  = or_ab;
            out_count_d = ONE_C;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        acc_d = acc_nx;
        cnt_d = cnt_nx;
        // A flush closes the window including a same-cycle sample.
        if ((accept && (cnt_nx == WIN_C)) || (bus.flush && (cnt_q != '0))) begin
          state_d     = HOLD;
          out_data_d  = acc_nx;
          out_count_d = cnt_nx;
        end
      end

      HOLD: begin
        if (emit_hs) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          out_data_d  = '0;
          out_count_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_or_window_accum.sv
module tb_or_window_accum;
  import or_accum_pkg::*;

  localparam int W   = 8;
  localparam int WIN = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  or_window_accum_if #(.W(W), .WINDOW(WIN)) bus ();
  or_window_accum_if #(.W(W), .WINDOW(1))   bus1 ();
  or_accum_state_t state;
  or_accum_state_t state1;

  or_window_accum #(.W(W), .WINDOW(WIN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  or_window_accum #(.W(W), .WINDOW(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus1.slave),
    .state_o (state1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Samples (a|b) of the open window, and finished windows waiting to be
  // taken, each stored as {count, data}.
  logic [W-1:0]   win_q[$];
  logic [W+2:0]   exp_q[$];
  bit             hold_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    win_q.delete();
    exp_q.delete();
    hold_m = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, drive the inputs,
  // then advance the model across the rising edge.
  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit fl, input bit ordy);
    logic [W-1:0] acc;
    int           pre;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(!hold_m));
    chk("out_valid", 32'(bus.out_valid), 32'(hold_m));
    if (hold_m) begin
      chk("out_data", 32'(bus.out_data), 32'(exp_q[0][W-1:0]));
      chk("out_count", 32'(bus.out_count), 32'(exp_q[0][W+2:W]));
    end
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.flush     = fl;
    bus.out_ready = ordy;
    @(posedge clk);
    if (hold_m) begin
      if (ordy) begin
        void'(exp_q.pop_front());
        hold_m = 1'b0;
      end
    end else begin
      pre = win_q.size();
      if (v) win_q.push_back(a | b);
      if (win_q.size() == WIN || (fl && pre > 0)) begin
        acc = '0;
        foreach (win_q[i]) acc |= win_q[i];
        exp_q.push_back({3'(win_q.size()), acc});
        win_q.delete();
        hold_m = 1'b1;
      end
    end
  endtask

  task automatic peek(input string tag, input bit v, input logic [W-1:0] d, input int c);
    #1;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    model_clear();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst_n        = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a6[4];
    logic [W-1:0] b6[4];
    n_checks = 0;
    n_errors = 0;
    model_clear();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.flush     = 1'b0;
    bus1.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // 1. full window
    step(1, 8'h01, 8'h00, 0, 1);
    step(1, 8'h00, 8'h02, 0, 1);
    step(1, 8'h04, 8'h00, 0, 1);
    step(1, 8'h00, 8'h80, 0, 1);
    peek("t1", 1, 8'h87, 4);
    step(0, 8'h00, 8'h00, 0, 1);
    step(0, 8'h00, 8'h00, 0, 1);

    // 2. flush closes a partial window; flush in IDLE does nothing
    step(1, 8'h10, 8'h00, 0, 1);
    step(1, 8'h00, 8'h01, 0, 1);
    step(0, 8'h00, 8'h00, 1, 1);
    peek("t2", 1, 8'h11, 2);
    step(0, 8'h00, 8'h00, 0, 1);
    step(0, 8'h00, 8'h00, 1, 1);
    peek("t2_idle_flush", 0, 8'h00, 0);

    // 3. backpressure holds the result stable
    step(1, 8'hF0, 8'h00, 0, 0);
    step(1, 8'h00, 8'h0C, 0, 0);
    step(1, 8'h03, 8'h00, 0, 0);
    step(1, 8'h00, 8'h00, 0, 0);
    peek("t3", 1, 8'hFF, 4);
    for (int i = 0; i < 5; i++)
      step(1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0);
    step(0, 8'h00, 8'h00, 0, 1);
    #1;
    chk("t3_in_ready", 32'(bus.in_ready), 32'd1);

    // 4. flush together with an accepted sample
    step(1, 8'h01, 8'h00, 0, 1);
    step(1, 8'h00, 8'h40, 1, 1);
    peek("t4", 1, 8'h41, 2);
    step(0, 8'h00, 8'h00, 0, 1);

    // 5. asynchronous reset mid-window and mid-hold
    step(1, 8'h55, 8'h00, 0, 1);
    step(1, 8'h00, 8'hAA, 0, 1);
    step(1, 8'h0F, 8'h00, 0, 1);
    async_reset("t5_win");
    for (int i = 0; i < 4; i++) step(1, 8'h00, 8'h00, 0, 1);
    peek("t5", 1, 8'h00, 4);
    step(0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h21, 8'h12, 0, 0);
    peek("t5_hold", 1, 8'h33, 4);
    async_reset("t5_hold_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, W'($urandom & $urandom & $urandom),
           W'($urandom & $urandom & $urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 0, 1);

    // 6. single-sample windows
    a6[0] = 8'h00; b6[0] = 8'h00;
    a6[1] = 8'hFF; b6[1] = 8'h00;
    a6[2] = 8'h00; b6[2] = 8'hFF;
    a6[3] = 8'hFF; b6[3] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus1.in_valid  = 1'b1;
      bus1.in_a      = a6[k];
      bus1.in_b      = b6[k];
      bus1.out_ready = 1'b1;
      @(negedge clk);
      chk("t6_valid", 32'(bus1.out_valid), 32'd1);
      chk("t6_data", 32'(bus1.out_data), 32'(a6[k] | b6[k]));
      chk("t6_count", 32'(bus1.out_count), 32'd1);
      chk("t6_in_ready", 32'(bus1.in_ready), 32'd0);
      bus1.in_valid = 1'b0;
      @(negedge clk);
      chk("t6_idle_valid", 32'(bus1.out_valid), 32'd0);
      chk("t6_idle_ready", 32'(bus1.in_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
